uart_rx_fsm_param: RTL and testbench

Parametrised UART receive controller that generalises the current RX FSM. It absorbs the edge/bit counters, the 3-sample majority sampler, the deserializer, and the start, parity and stop checks into one block. It supports configurable data width, runtime prescale, even/odd/no parity and 1 or 2 stop bits. It sits between the RX_IN pin synchroniser and the RX data consumer; one clock runs at prescale × baud.

---
 rtl/uart_rx_pkg.sv | 20 ++
 rtl/uart_rx_fsm_param_if.sv | 27 ++
 rtl/uart_rx_data_sampler.sv | 34 +++
 rtl/uart_rx_fsm_param.sv | 120 ++++++++++++
 tb/tb_uart_rx_fsm_param.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the parametrised UART receiver.
// Holds the FSM state encoding and the prescale legalisation helper.
package uart_rx_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    localparam int unsigned PRESCALE_8  = 8;
    localparam int unsigned PRESCALE_16 = 16;
    localparam int unsigned PRESCALE_32 = 32;

    // Anything other than 16 or 32 runs at 8x oversampling.
    function automatic int unsigned eff_prescale(input int unsigned p);
        if (p == PRESCALE_16 || p == PRESCALE_32) return p;
        return PRESCALE_8;
    endfunction

endpackage

// File: rtl/uart_rx_fsm_param_if.sv
// Serial line, runtime configuration and result strobes of the UART receiver.
// The receiver is the slave; the line driver and consumer side is the master.
interface uart_rx_fsm_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
);
    logic                  RX_IN;
    logic [PRESCALE_W-1:0] prescale;
    logic                  parity_enable;
    logic                  parity_type;
    logic                  stop_bits;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  parity_error;
    logic                  stop_error;
    logic                  busy;

    modport master (
        output RX_IN, prescale, parity_enable, parity_type, stop_bits,
        input  P_DATA, data_valid, parity_error, stop_error, busy
    );

    modport slave (
        input  RX_IN, prescale, parity_enable, parity_type, stop_bits,
        output P_DATA, data_valid, parity_error, stop_error, busy
    );
endinterface

// File: rtl/uart_rx_data_sampler.sv
// 3-sample majority voter around mid-bit (edges P/2-1, P/2, P/2+1).
// sample_done strobes on edge P/2+1 so the caller registers the vote by P/2+2.
module uart_rx_data_sampler #(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  active,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    input  logic [PRESCALE_W-1:0] p,
    input  logic                  rx,
    output logic                  maj_bit,
    output logic                  sample_done
);
    logic [PRESCALE_W-1:0] half;
    logic                  s0, s1;

    assign half = p >> 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
        end else if (active) begin
            if (edge_cnt == half - PRESCALE_W'(1)) s0 <= rx;
            if (edge_cnt == half)                  s1 <= rx;
        end
    end

    // Third sample is the live line value on the voting edge.
    assign maj_bit     = (s0 & s1) | (s0 & rx) | (s1 & rx);
    assign sample_done = active && (edge_cnt == half + PRESCALE_W'(1));

endmodule

// File: rtl/uart_rx_fsm_param.sv
// UART receive controller: start/data/parity/stop FSM with oversampled majority sampling.
// Result strobes appear P*(frame bits) cycles after the start-bit detect; no backpressure.
module uart_rx_fsm_param
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                clk_based_on_prescale,
    input  logic                asy_reset,
    uart_rx_fsm_param_if.slave  rx
);
    localparam int BIT_W = $clog2(DATA_WIDTH + 5);

    state_t                  state, state_n;
    logic [PRESCALE_W-1:0]   edge_cnt, p_lat;
    logic [BIT_W-1:0]        bit_cnt;
    logic                    par_en_lat, par_type_lat, stop2_lat;
    logic [DATA_WIDTH-1:0]   shreg;
    logic                    samp_bit, maj_bit, sample_done;
    logic                    par_err, stop_err;
    logic                    eob, detect, last_data, last_bit, frame_done, stop_bad, par_exp;

    uart_rx_data_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
        .clk         (clk_based_on_prescale),
        .rst         (asy_reset),
        .active      (state != IDLE),
        .edge_cnt    (edge_cnt),
        .p           (p_lat),
        .rx          (rx.RX_IN),
        .maj_bit     (maj_bit),
        .sample_done (sample_done)
    );

    // Bit 0 is the start bit, so data bits occupy bit_cnt 1..DATA_WIDTH.
    assign eob        = (state != IDLE) && (edge_cnt == p_lat - PRESCALE_W'(1));
    assign detect     = (state == IDLE) && !rx.RX_IN;
    assign last_data  = (bit_cnt == BIT_W'(DATA_WIDTH));
    assign last_bit   = (bit_cnt == BIT_W'(DATA_WIDTH + 1) + BIT_W'(par_en_lat) + BIT_W'(stop2_lat));
    assign frame_done = (state == STOP) && eob && last_bit;
    assign stop_bad   = stop_err | ~samp_bit;
    assign par_exp    = (^shreg) ^ (par_type_lat == PARITY_ODD);
    assign rx.busy    = (state != IDLE);

    always_ff @(posedge clk_based_on_prescale) begin
        if (asy_reset) state <= IDLE;
        else           state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (!rx.RX_IN) state_n = START;
            START:   if (eob) state_n = samp_bit ? IDLE : DATA;
            DATA:    if (eob && last_data) state_n = par_en_lat ? PARITY : STOP;
            PARITY:  if (eob) state_n = STOP;
            STOP:    if (eob && last_bit) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_based_on_prescale) begin
        if (asy_reset) begin
            edge_cnt        <= '0;
            bit_cnt         <= '0;
            p_lat           <= PRESCALE_W'(PRESCALE_8);
            par_en_lat      <= 1'b0;
            par_type_lat    <= 1'b0;
            stop2_lat       <= 1'b0;
            shreg           <= '0;
            samp_bit        <= 1'b0;
            par_err         <= 1'b0;
            stop_err        <= 1'b0;
            rx.P_DATA       <= '0;
            rx.data_valid   <= 1'b0;
            rx.parity_error <= 1'b0;
            rx.stop_error   <= 1'b0;
        end else begin
            rx.data_valid   <= 1'b0;
            rx.parity_error <= 1'b0;
            rx.stop_error   <= 1'b0;

            if (detect) begin
                edge_cnt     <= PRESCALE_W'(1);
                bit_cnt      <= '0;
                p_lat        <= PRESCALE_W'(eff_prescale(32'(rx.prescale)));
                par_en_lat   <= rx.parity_enable;
                par_type_lat <= rx.parity_type;
                stop2_lat    <= rx.stop_bits;
                par_err      <= 1'b0;
                stop_err     <= 1'b0;
            end else if (state == IDLE) begin
                edge_cnt <= '0;
                bit_cnt  <= '0;
            end else if (eob) begin
                edge_cnt <= '0;
                bit_cnt  <= bit_cnt + BIT_W'(1);
            end else begin
                edge_cnt <= edge_cnt + PRESCALE_W'(1);
            end

            if (sample_done) samp_bit <= maj_bit;

            // Right shift so the first (LSB) data bit ends up at bit 0.
            if (state == DATA && eob) shreg <= {samp_bit, shreg[DATA_WIDTH-1:1]};
            if (state == PARITY && eob && samp_bit != par_exp) par_err <= 1'b1;
            if (state == STOP && eob && !samp_bit) stop_err <= 1'b1;

            if (frame_done) begin
                rx.parity_error <= par_err;
                rx.stop_error   <= stop_bad;
                if (!par_err && !stop_bad) begin
                    rx.data_valid <= 1'b1;
                    rx.P_DATA     <= shreg;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fsm_param.sv
// Directed bench for uart_rx_fsm_param: an 8-bit and a 9-bit instance on one clock.
module tb_uart_rx_fsm_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   passed = 0;
    int   total = 0;

    int dv8 = 0, pe8 = 0, se8 = 0, dv9 = 0;
    int dv8_cyc = -1, pe8_cyc = -1, se8_cyc = -1, dv9_cyc = -1;

    uart_rx_fsm_param_if #(.DATA_WIDTH(8), .PRESCALE_W(6)) if8 ();
    uart_rx_fsm_param_if #(.DATA_WIDTH(9), .PRESCALE_W(6)) if9 ();

    uart_rx_fsm_param #(.DATA_WIDTH(8), .PRESCALE_W(6)) u8 (
        .clk_based_on_prescale (clk),
        .asy_reset             (rst),
        .rx                    (if8.slave)
    );

    uart_rx_fsm_param #(.DATA_WIDTH(9), .PRESCALE_W(6)) u9 (
        .clk_based_on_prescale (clk),
        .asy_reset             (rst),
        .rx                    (if9.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (if8.data_valid)   begin dv8++; dv8_cyc = cyc; end
        if (if8.parity_error) begin pe8++; pe8_cyc = cyc; end
        if (if8.stop_error)   begin se8++; se8_cyc = cyc; end
        if (if9.data_valid)   begin dv9++; dv9_cyc = cyc; end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame bits, first on the wire at index 0.
    task automatic mk(input logic [8:0] d, input int dw, input logic has_par, input logic par_bit,
                      input logic two_stop, input logic stop2, output logic [15:0] v, output int n);
        v = '1;
        v[0] = 1'b0;
        for (int i = 0; i < dw; i++) v[1+i] = d[i];
        n = 1 + dw;
        if (has_par) begin v[n] = par_bit; n++; end
        v[n] = 1'b1; n++;
        if (two_stop) begin v[n] = stop2; n++; end
    endtask

    task automatic drive(input logic sel9, input logic [15:0] v, input int first, input int last, input int p);
        for (int b = first; b <= last; b++) begin
            for (int c = 0; c < p; c++) begin
                if (sel9) begin
                    if9.RX_IN = v[b];
                end else begin
                    if8.RX_IN = v[b];
                end
                tick();
            end
        end
    endtask

    task automatic cfg8(input logic [5:0] p, input logic pe, input logic pt, input logic sb);
        if8.prescale = p; if8.parity_enable = pe; if8.parity_type = pt; if8.stop_bits = sb;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        total++; if (if8.P_DATA !== 8'h00) $display("FAIL rst_pdata8: got %h want 00", if8.P_DATA); else passed++;
        total++; if ({if8.data_valid, if8.parity_error, if8.stop_error, if8.busy} !== 4'b0000)
            $display("FAIL rst_flags8: got %b want 0000", {if8.data_valid, if8.parity_error, if8.stop_error, if8.busy}); else passed++;
        total++; if ({if9.P_DATA, if9.data_valid, if9.busy} !== 11'd0)
            $display("FAIL rst_u9: got %h want 000", {if9.P_DATA, if9.data_valid, if9.busy}); else passed++;
        rst = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_8n1();
        logic [15:0] v; int n, t, d0;
        cfg8(6'd8, 1'b0, 1'b0, 1'b0);
        mk(9'h0A5, 8, 1'b0, 1'b0, 1'b0, 1'b0, v, n);
        t = cyc; d0 = dv8;
        drive(1'b0, v, 0, 8, 8);
        total++; if (if8.busy !== 1'b1) $display("FAIL n81_busy_mid: got %b want 1", if8.busy); else passed++;
        drive(1'b0, v, 9, n - 1, 8);
        if8.RX_IN = 1'b1;
        total++; if (if8.data_valid !== 1'b1) $display("FAIL n81_dv: got %b want 1", if8.data_valid); else passed++;
        total++; if (if8.P_DATA !== 8'hA5) $display("FAIL n81_data: got %h want a5", if8.P_DATA); else passed++;
        total++; if ({if8.parity_error, if8.stop_error, if8.busy} !== 3'b000)
            $display("FAIL n81_err_busy: got %b want 000", {if8.parity_error, if8.stop_error, if8.busy}); else passed++;
        tick();
        total++; if (if8.data_valid !== 1'b0) $display("FAIL n81_pulse_width: got %b want 0", if8.data_valid); else passed++;
        total++; if (dv8 != d0 + 1 || dv8_cyc != t + 80)
            $display("FAIL n81_timing: got count %0d cyc %0d want count %0d cyc %0d", dv8 - d0, dv8_cyc - t, 1, 80); else passed++;
        repeat (3) tick();
    endtask

    task automatic test_glitch();
        logic [15:0] v; int n, t, d0, p0, s0;
        cfg8(6'd8, 1'b0, 1'b0, 1'b0);
        d0 = dv8; p0 = pe8; s0 = se8; t = cyc;
        if8.RX_IN = 1'b0;
        repeat (3) tick();
        if8.RX_IN = 1'b1;
        repeat (4) tick();
        total++; if (if8.busy !== 1'b1) $display("FAIL glitch_busy_t7: got %b want 1", if8.busy); else passed++;
        tick();
        total++; if (if8.busy !== 1'b0) $display("FAIL glitch_idle_t8: got %b want 0 (cyc %0d)", if8.busy, cyc - t); else passed++;
        repeat (5) tick();
        total++; if (dv8 != d0 || pe8 != p0 || se8 != s0)
            $display("FAIL glitch_pulses: got %0d/%0d/%0d want 0/0/0", dv8 - d0, pe8 - p0, se8 - s0); else passed++;
        mk(9'h03C, 8, 1'b0, 1'b0, 1'b0, 1'b0, v, n);
        t = cyc;
        drive(1'b0, v, 0, n - 1, 8);
        if8.RX_IN = 1'b1;
        total++; if (if8.data_valid !== 1'b1 || if8.P_DATA !== 8'h3C)
            $display("FAIL glitch_next_frame: got dv %b data %h want 1 3c", if8.data_valid, if8.P_DATA); else passed++;
        tick();
        total++; if (dv8_cyc != t + 80) $display("FAIL glitch_next_lat: got %0d want 80", dv8_cyc - t); else passed++;
        repeat (3) tick();
    endtask

    task automatic test_parity_error();
        logic [15:0] v; int n, t, d0;
        cfg8(6'd16, 1'b1, 1'b0, 1'b0);
        mk(9'h007, 8, 1'b1, 1'b0, 1'b0, 1'b0, v, n);
        t = cyc; d0 = dv8;
        drive(1'b0, v, 0, n - 1, 16);
        if8.RX_IN = 1'b1;
        total++; if ({if8.parity_error, if8.stop_error, if8.data_valid} !== 3'b100)
            $display("FAIL par_flags: got %b want 100", {if8.parity_error, if8.stop_error, if8.data_valid}); else passed++;
        total++; if (if8.P_DATA !== 8'h3C) $display("FAIL par_hold_data: got %h want 3c", if8.P_DATA); else passed++;
        tick();
        total++; if (if8.parity_error !== 1'b0) $display("FAIL par_pulse_width: got %b want 0", if8.parity_error); else passed++;
        total++; if (pe8_cyc != t + 176 || dv8 != d0)
            $display("FAIL par_timing: got cyc %0d dv %0d want 176 0", pe8_cyc - t, dv8 - d0); else passed++;
        repeat (3) tick();
    endtask

    task automatic test_stop_bits();
        logic [15:0] v; int n, t;
        cfg8(6'd16, 1'b0, 1'b0, 1'b1);
        mk(9'h081, 8, 1'b0, 1'b0, 1'b1, 1'b0, v, n);
        t = cyc;
        drive(1'b0, v, 0, n - 1, 16);
        if8.RX_IN = 1'b1;
        total++; if ({if8.stop_error, if8.parity_error, if8.data_valid} !== 3'b100)
            $display("FAIL stop_flags: got %b want 100", {if8.stop_error, if8.parity_error, if8.data_valid}); else passed++;
        total++; if (if8.P_DATA !== 8'h3C) $display("FAIL stop_hold_data: got %h want 3c", if8.P_DATA); else passed++;
        tick();
        total++; if (se8_cyc != t + 176) $display("FAIL stop_lat: got %0d want 176", se8_cyc - t); else passed++;
        tick();
        mk(9'h081, 8, 1'b0, 1'b0, 1'b1, 1'b1, v, n);
        t = cyc;
        drive(1'b0, v, 0, n - 1, 16);
        if8.RX_IN = 1'b1;
        total++; if (if8.data_valid !== 1'b1 || if8.P_DATA !== 8'h81 || if8.stop_error !== 1'b0)
            $display("FAIL stop2_good: got dv %b data %h se %b want 1 81 0", if8.data_valid, if8.P_DATA, if8.stop_error); else passed++;
        tick();
        total++; if (dv8_cyc != t + 176) $display("FAIL stop2_lat: got %0d want 176", dv8_cyc - t); else passed++;
        repeat (3) tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] v1, v2; int n1, n2, t, d0;
        if9.prescale = 6'd32; if9.parity_enable = 1'b1; if9.parity_type = 1'b1; if9.stop_bits = 1'b0;
        mk(9'h1FF, 9, 1'b1, 1'b0, 1'b0, 1'b0, v1, n1);
        mk(9'h000, 9, 1'b1, 1'b1, 1'b0, 1'b0, v2, n2);
        t = cyc; d0 = dv9;
        drive(1'b1, v1, 0, n1 - 1, 32);
        total++; if (if9.data_valid !== 1'b1 || if9.P_DATA !== 9'h1FF)
            $display("FAIL b2b_first: got dv %b data %h want 1 1ff", if9.data_valid, if9.P_DATA); else passed++;
        drive(1'b1, v2, 0, n2 - 1, 32);
        if9.RX_IN = 1'b1;
        total++; if (if9.data_valid !== 1'b1 || if9.P_DATA !== 9'h000)
            $display("FAIL b2b_second: got dv %b data %h want 1 000", if9.data_valid, if9.P_DATA); else passed++;
        tick();
        total++; if (dv9 != d0 + 2 || dv9_cyc != t + 768)
            $display("FAIL b2b_timing: got count %0d cyc %0d want 2 768", dv9 - d0, dv9_cyc - t); else passed++;
        repeat (3) tick();
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] v; int n, t, d0, p0, s0;
        cfg8(6'd8, 1'b0, 1'b0, 1'b0);
        mk(9'h05A, 8, 1'b0, 1'b0, 1'b0, 1'b0, v, n);
        d0 = dv8; p0 = pe8; s0 = se8;
        drive(1'b0, v, 0, 3, 8);
        rst = 1'b1;
        if8.RX_IN = 1'b1;
        tick();
        total++; if (if8.P_DATA !== 8'h00) $display("FAIL midrst_pdata: got %h want 00", if8.P_DATA); else passed++;
        total++; if ({if8.data_valid, if8.parity_error, if8.stop_error, if8.busy} !== 4'b0000)
            $display("FAIL midrst_flags: got %b want 0000", {if8.data_valid, if8.parity_error, if8.stop_error, if8.busy}); else passed++;
        rst = 1'b0;
        repeat (20) tick();
        total++; if (dv8 != d0 || pe8 != p0 || se8 != s0)
            $display("FAIL midrst_pulses: got %0d/%0d/%0d want 0/0/0", dv8 - d0, pe8 - p0, se8 - s0); else passed++;
        t = cyc;
        drive(1'b0, v, 0, 4, 8);
        cfg8(6'd16, 1'b1, 1'b1, 1'b1);
        drive(1'b0, v, 5, n - 1, 8);
        if8.RX_IN = 1'b1;
        total++; if (if8.data_valid !== 1'b1 || if8.P_DATA !== 8'h5A)
            $display("FAIL midcfg_frame: got dv %b data %h want 1 5a", if8.data_valid, if8.P_DATA); else passed++;
        tick();
        total++; if (dv8_cyc != t + 80 || pe8 != p0 || se8 != s0)
            $display("FAIL midcfg_timing: got cyc %0d pe %0d se %0d want 80 0 0", dv8_cyc - t, pe8 - p0, se8 - s0); else passed++;
        repeat (3) tick();
    endtask

    initial begin
        if8.RX_IN = 1'b1; if9.RX_IN = 1'b1;
        cfg8(6'd8, 1'b0, 1'b0, 1'b0);
        if9.prescale = 6'd32; if9.parity_enable = 1'b1; if9.parity_type = 1'b1; if9.stop_bits = 1'b0;
        test_reset();
        test_8n1();
        test_glitch();
        test_parity_error();
        test_stop_bits();
        test_back_to_back();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
